// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data-memory responder family.
// Holds the responder state encoding, word/byte geometry and the byte-lane
// merge helper used by the word RAM. Future cache and instruction-memory
// responders import the same package so their encodings stay identical.
package data_memory_responder_pkg;

  // Responder handshake states; encoding is fixed so other responders match.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dm_state_e;

  localparam int WORD_BITS      = 32;
  localparam int BYTE_BITS      = 8;
  localparam int BYTES_PER_WORD = WORD_BITS / BYTE_BITS;

  // Wait counter holds LATENCY+1 (up to 16), so it needs five bits.
  localparam int CNT_BITS       = 5;

  // Replace the enabled byte lanes of old_word with the matching lanes of new_word.
  function automatic logic [WORD_BITS-1:0] lane_merge(
    input logic [WORD_BITS-1:0]      old_word,
    input logic [WORD_BITS-1:0]      new_word,
    input logic [BYTES_PER_WORD-1:0] lane_en
  );
    logic [WORD_BITS-1:0] merged;
    merged = old_word;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (lane_en[i]) begin
        merged[i*BYTE_BITS +: BYTE_BITS] = new_word[i*BYTE_BITS +: BYTE_BITS];
      end else begin
        merged[i*BYTE_BITS +: BYTE_BITS] = old_word[i*BYTE_BITS +: BYTE_BITS];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_memory_responder_dm_word_ram.sv
// dm_word_ram: DEPTH_WORDS x 32-bit storage for the data-memory responder.
// Ports:
//   clk     - rising-edge clock
//   commit  - write strobe; the RAM changes only on an edge where this is high
//   addr    - word index shared by read and write
//   wdata   - store data
//   byte_en - store lane enables, bit i covers bits [8i+7:8i]
//   rdata   - combinational read of the addressed word
// Contents are deliberately not reset.
module dm_word_ram
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_BITS   = 8
) (
  input  logic                      clk,
  input  logic                      commit,
  input  logic [ADDR_BITS-1:0]      addr,
  input  logic [WORD_BITS-1:0]      wdata,
  input  logic [BYTES_PER_WORD-1:0] byte_en,
  output logic [WORD_BITS-1:0]      rdata
);

  logic [WORD_BITS-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_BITS-1:0] mem_word_d;

  assign rdata = mem_q[addr];

  // Build the post-store word so disabled lanes keep their old contents.
  always_comb begin
    mem_word_d = lane_merge(mem_q[addr], wdata, byte_en);
  end

  // Write the merged word only when the responder commits a store.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem_q[addr] <= mem_word_d;
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: multi-cycle valid/ready data-memory target for the
// CPU load/store port, with programmable wait states, byte enables and
// error reporting.
// Ports:
//   clk, resetN                      - clock, asynchronous active-low reset
//   reqValid/reqReady                - request handshake
//   reqWrite, reqAddress,
//   reqWriteData, reqByteEnable      - request fields (captured on accept)
//   respValid/respReady              - response handshake (held until consumed)
//   respReadData, respError          - response payload
// A request is captured on the accept edge; the error check and RAM access
// happen on the edge that raises respValid, LATENCY+1 edges later.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 256,
  parameter int unsigned LATENCY      = 2,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        reqValid,
  input  logic        reqWrite,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqWriteData,
  input  logic [3:0]  reqByteEnable,
  output logic        reqReady,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] respReadData,
  output logic        respError
);

  localparam int unsigned ADDR_BITS = (DEPTH_WORDS > 32'd1) ? $clog2(DEPTH_WORDS) : 32'd1;
  localparam logic [CNT_BITS-1:0] CNT_ONE   = {{(CNT_BITS-1){1'b0}}, 1'b1};
  // Loading LATENCY+1 and leaving WAIT at count==1 puts the response edge
  // exactly LATENCY+1 edges after the accept edge, including LATENCY=0.
  localparam logic [CNT_BITS-1:0] WAIT_LOAD = CNT_BITS'(LATENCY + 32'd1);

  dm_state_e                 state_q, state_d;
  logic [CNT_BITS-1:0]       count_q, count_d;
  logic                      write_q, write_d;
  logic [31:0]               addr_q, addr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [3:0]                be_q, be_d;
  logic                      resp_valid_q, resp_valid_d;
  logic                      resp_error_q, resp_error_d;
  logic [31:0]               resp_data_q, resp_data_d;

  logic [31:0]               offset_s;
  logic [31:0]               word_idx_s;
  logic                      addr_err_s;
  logic                      commit_s;
  logic [ADDR_BITS-1:0]      ram_addr_s;
  logic [31:0]               ram_rdata_s;

  // Unsigned offset; an address below the base wraps high but is flagged separately.
  assign offset_s    = addr_q - BASE_ADDRESS;
  assign word_idx_s  = offset_s >> 2'd2;
  assign addr_err_s  = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDRESS) ||
                       (word_idx_s >= DEPTH_WORDS);
  assign ram_addr_s  = word_idx_s[ADDR_BITS-1:0];

  assign reqReady     = (state_q == ST_IDLE) && resetN;
  assign respValid    = resp_valid_q;
  assign respError    = resp_error_q;
  assign respReadData = resp_data_q;

  dm_word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_BITS   (ADDR_BITS)
  ) u_ram (
    .clk     (clk),
    .commit  (commit_s),
    .addr    (ram_addr_s),
    .wdata   (wdata_q),
    .byte_en (be_q),
    .rdata   (ram_rdata_s)
  );

  // Next-state, capture, access and response computation for the handshake FSM.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    resp_valid_d = resp_valid_q;
    resp_error_d = resp_error_q;
    resp_data_d  = resp_data_q;
    commit_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (reqValid) begin
          write_d = reqWrite;
          addr_d  = reqAddress;
          wdata_d = reqWriteData;
          be_d    = reqByteEnable;
          count_d = WAIT_LOAD;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (count_q == CNT_ONE) begin
          // Response edge: the access commits here and nowhere else.
          state_d      = ST_RESP;
          count_d      = '0;
          resp_valid_d = 1'b1;
          if (addr_err_s) begin
            resp_error_d = 1'b1;
            resp_data_d  = 32'h0000_0000;
          end else if (write_q) begin
            commit_s     = 1'b1;
            resp_error_d = 1'b0;
            resp_data_d  = 32'h0000_0000;
          end else begin
            resp_error_d = 1'b0;
            resp_data_d  = ram_rdata_s;
          end
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end

      ST_RESP: begin
        if (respReady) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_error_d = 1'b0;
          resp_data_d  = 32'h0000_0000;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        count_d      = '0;
        resp_valid_d = 1'b0;
        resp_error_d = 1'b0;
        resp_data_d  = 32'h0000_0000;
      end
    endcase
  end

  // FSM state, captured request and registered response outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      write_q      <= 1'b0;
      addr_q       <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      be_q         <= 4'h0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_data_q  <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_data_q  <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder. Three instances cover
// LATENCY=2 (main tests), LATENCY=4 and LATENCY=0 (reset mid-wait).
// Stimulus pushes expected responses; a negedge monitor pops and compares
// whenever an instance raises respValid.
module tb_data_memory_responder;

  typedef struct {
    int          tag;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  logic        clk = 1'b0;
  logic        reset_n    [3];
  logic        req_valid  [3];
  logic        req_write  [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [3:0]  req_be     [3];
  logic        req_ready  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_data  [3];
  logic        resp_error [3];
  logic        prev_valid [3] = '{1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_memory_responder #(
      .DEPTH_WORDS  (256),
      .LATENCY      ((g == 0) ? 2 : ((g == 1) ? 4 : 0)),
      .BASE_ADDRESS (32'h0000_0000)
    ) u_dut (
      .clk           (clk),
      .resetN        (reset_n[g]),
      .reqValid      (req_valid[g]),
      .reqWrite      (req_write[g]),
      .reqAddress    (req_addr[g]),
      .reqWriteData  (req_wdata[g]),
      .reqByteEnable (req_be[g]),
      .reqReady      (req_ready[g]),
      .respValid     (resp_valid[g]),
      .respReady     (resp_ready[g]),
      .respReadData  (resp_data[g]),
      .respError     (resp_error[g])
    );
  end

  function automatic int lat_of(input int i);
    case (i)
      0:       return 2;
      1:       return 4;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present a request and hold it until accepted; optionally expect a response.
  task automatic issue(input int i, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_data, input logic exp_err,
                       input bit expect_resp);
    bit   got;
    exp_t e;
    got = 1'b0;
    @(negedge clk);
    req_write[i] = wr;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    req_be[i]    = be;
    req_valid[i] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (req_ready[i]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout inst=%0d actual=not_ready required=ready", i);
      req_valid[i] = 1'b0;
    end else begin
      if (expect_resp) begin
        e.tag  = i;
        e.data = exp_data;
        e.err  = exp_err;
        e.cyc  = cyc + 2 + lat_of(i);
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      req_valid[i] = 1'b0;
    end
  endtask

  task automatic wait_ready(input int i);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout inst=%0d actual=busy required=idle", i);
    end
  endtask

  task automatic txn(input int i, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input logic [31:0] exp_data, input logic exp_err);
    issue(i, wr, addr, wdata, be, exp_data, exp_err, 1'b1);
    wait_ready(i);
  endtask

  // Response monitor: compare each newly presented response with the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid[i] && !prev_valid[i]) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp inst=%0d actual=valid required=no_response", i);
        end else begin
          e = sb.pop_front();
          chk("resp_inst", 32'(i), 32'(e.tag));
          chk("resp_data", resp_data[i], e.data);
          chk("resp_err", {31'd0, resp_error[i]}, {31'd0, e.err});
          chk("resp_latency", 32'(cyc), 32'(e.cyc));
        end
      end
    end
    prev_valid <= resp_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    for (int i = 0; i < 3; i++) begin
      reset_n[i]    = 1'b0;
      req_valid[i]  = 1'b0;
      req_write[i]  = 1'b0;
      req_addr[i]   = 32'h0;
      req_wdata[i]  = 32'h0;
      req_be[i]     = 4'h0;
      resp_ready[i] = 1'b1;
    end

    // 1: reset held with a pending request -> nothing accepted
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h10;
    req_wdata[0] = 32'h5555_5555;
    req_be[0]    = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready[0]}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid[0]}, 32'd0);
    end
    chk("rst_resp_data", resp_data[0], 32'h0);
    chk("rst_resp_err", {31'd0, resp_error[0]}, 32'd0);
    req_valid[0] = 1'b0;
    for (int i = 0; i < 3; i++) reset_n[i] = 1'b1;
    @(negedge clk);
    chk("rel_req_ready0", {31'd0, req_ready[0]}, 32'd1);
    chk("rel_req_ready1", {31'd0, req_ready[1]}, 32'd1);
    chk("rel_req_ready2", {31'd0, req_ready[2]}, 32'd1);

    // 2: store then load, LATENCY=2
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

    // 3: byte enables, including an all-lanes-off store
    txn(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
    txn(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);
    txn(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);

    // 4: misaligned and out-of-range requests
    txn(0, 1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1);
    txn(0, 1'b1, 32'h3FC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
    txn(0, 1'b1, 32'h0, 32'h0BAD_C0DE, 4'hF, 32'h0, 1'b0);
    txn(0, 1'b1, 32'h400, 32'h7777_7777, 4'hF, 32'h0, 1'b1);
    txn(0, 1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1);
    txn(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0BAD_C0DE, 1'b0);
    txn(0, 1'b1, 32'h12, 32'h6666_6666, 4'hF, 32'h0, 1'b1);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

    // 5: response backpressure
    resp_ready[0] = 1'b0;
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (resp_valid[0]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bp_resp_seen", {31'd0, seen}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'd0, resp_valid[0]}, 32'd1);
      chk("bp_hold_data", resp_data[0], 32'hDEAD_BEEF);
      chk("bp_req_ready", {31'd0, req_ready[0]}, 32'd0);
    end
    resp_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, resp_valid[0]}, 32'd0);
    chk("bp_release_ready", {31'd0, req_ready[0]}, 32'd1);
    chk("bp_release_data", resp_data[0], 32'h0);

    // 6a: LATENCY=4, reset two cycles after accepting a store
    txn(1, 1'b1, 32'h40, 32'h0000_AAAA, 4'hF, 32'h0, 1'b0);
    issue(1, 1'b1, 32'h40, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n[1] = 1'b0;
    @(negedge clk);
    chk("l4_rst_valid", {31'd0, resp_valid[1]}, 32'd0);
    chk("l4_rst_ready", {31'd0, req_ready[1]}, 32'd0);
    reset_n[1] = 1'b1;
    @(negedge clk);
    txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0000_AAAA, 1'b0);

    // 6b: LATENCY=0, one-cycle response and reset before the commit edge
    txn(2, 1'b1, 32'h44, 32'h0000_00BB, 4'hF, 32'h0, 1'b0);
    txn(2, 1'b0, 32'h44, 32'h0, 4'h0, 32'h0000_00BB, 1'b0);
    issue(2, 1'b1, 32'h44, 32'h0000_0099, 4'hF, 32'h0, 1'b0, 1'b0);
    reset_n[2] = 1'b0;
    @(negedge clk);
    chk("l0_rst_valid", {31'd0, resp_valid[2]}, 32'd0);
    reset_n[2] = 1'b1;
    @(negedge clk);
    txn(2, 1'b0, 32'h44, 32'h0, 4'h0, 32'h0000_00BB, 1'b0);

    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
